neopixel_frame_ctrl: RTL

Sequences one WS2812 (NeoPixel) frame transfer. It takes the synchronized KEY0 and SW1:SW0 levels, fetches NUM_PIXELS 24-bit GRB words from the pixel memory read port, and hands each word to the bit serializer over a valid/ready handshake. After the last pixel has shifted out, it enforces the latch (reset) gap. It sits between the input synchronizer stage and the serializer/pixel RAM in the LED controller top level.

---
 rtl/neopixel_frame_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/neopixel_frame_ctrl.sv
// WS2812 frame sequencer: fetches NUM_PIXELS GRB words, hands each to the serializer, then holds the latch gap.
// Optional macro DIM_EN: mode 11 sends a dimmed frame (each colour byte >> 2); otherwise mode 11 behaves as mode 00.
module neopixel_frame_ctrl #(
   parameter int NUM_PIXELS   = 5,
   parameter int ADDR_W       = 3,
   parameter int LATCH_CYCLES = 2500
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              key_n,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
   output logic              ser_valid,
   output logic [23:0]       ser_data,
   input  logic              ser_ready,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      DRAIN,
      LATCH
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        mode_q;
   logic              key_q;
   logic              armed_q;
   logic              ser_valid_q;
   logic [23:0]       ser_data_q;
   logic              busy_q;
   logic              frame_done_q;
   logic [23:0]       load_d;
   logic              start;

   // armed_q blocks a key that is already held when reset releases from looking like a fresh press.
   assign start = armed_q & key_q & ~key_n;

   // NOTE: load_d is given a value before the case so no path through this block can infer a latch.
   always_comb begin
      load_d = rd_data;
      case (mode_q)
         2'b10:   load_d = 24'h000000;
`ifdef DIM_EN
         2'b11:   load_d = {2'b00, rd_data[23:18], 2'b00, rd_data[15:10], 2'b00, rd_data[7:2]};
`endif
         default: load_d = rd_data;
      endcase
   end

   // NOTE: every register here is state, so all assignments are non-blocking and reset is sampled on the clock.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         mode_q       <= 2'b00;
         key_q        <= 1'b1;
         armed_q      <= 1'b0;
         ser_valid_q  <= 1'b0;
         ser_data_q   <= 24'h000000;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         key_q        <= key_n;
         frame_done_q <= 1'b0;
         if (key_n) begin
            armed_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  idx_q   <= '0;
                  mode_q  <= mode;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               state_q <= LOAD;
            end
            LOAD: begin
               ser_data_q  <= load_d;
               ser_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (ser_ready) begin
                  ser_valid_q <= 1'b0;
                  if (idx_q == IDX_LAST) begin
                     state_q <= DRAIN;
                  end else begin
                     idx_q   <= idx_q + ADDR_W'(1);
                     state_q <= FETCH;
                  end
               end
            end
            DRAIN: begin
               if (ser_ready) begin
                  state_q      <= LATCH;
                  cnt_q        <= '0;
                  frame_done_q <= (CNT_LAST == '0);
               end
            end
            LATCH: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (mode == 2'b01) begin
                     state_q <= FETCH;
                     idx_q   <= '0;
                     mode_q  <= mode;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q        <= cnt_q + CNT_ONE;
                  frame_done_q <= ((cnt_q + CNT_ONE) == CNT_LAST);
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               ser_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign rd_addr    = idx_q;
   assign ser_valid  = ser_valid_q;
   assign ser_data   = ser_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
